// File: rtl/neko_axil_arbiter.sv
// Two-master AXI4-Lite arbiter in front of the compute-unit slave port.
// One transaction in flight; round-robin between masters at transaction granularity.
module neko_axil_arbiter #(
  parameter int unsigned ADDR_WIDTH = 11,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                      chipset_clk,
  input  logic                      rst_n,
  // master 0 (NoC bridge)
  input  logic [ADDR_WIDTH-1:0]     s0_awaddr,
  input  logic [2:0]                s0_awprot,
  input  logic                      s0_awvalid,
  output logic                      s0_awready,
  input  logic [DATA_WIDTH-1:0]     s0_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s0_wstrb,
  input  logic                      s0_wvalid,
  output logic                      s0_wready,
  output logic [1:0]                s0_bresp,
  output logic                      s0_bvalid,
  input  logic                      s0_bready,
  input  logic [ADDR_WIDTH-1:0]     s0_araddr,
  input  logic [2:0]                s0_arprot,
  input  logic                      s0_arvalid,
  output logic                      s0_arready,
  output logic [DATA_WIDTH-1:0]     s0_rdata,
  output logic [1:0]                s0_rresp,
  output logic                      s0_rvalid,
  input  logic                      s0_rready,
  // master 1
  input  logic [ADDR_WIDTH-1:0]     s1_awaddr,
  input  logic [2:0]                s1_awprot,
  input  logic                      s1_awvalid,
  output logic                      s1_awready,
  input  logic [DATA_WIDTH-1:0]     s1_wdata,
  input  logic [DATA_WIDTH/8-1:0]   s1_wstrb,
  input  logic                      s1_wvalid,
  output logic                      s1_wready,
  output logic [1:0]                s1_bresp,
  output logic                      s1_bvalid,
  input  logic                      s1_bready,
  input  logic [ADDR_WIDTH-1:0]     s1_araddr,
  input  logic [2:0]                s1_arprot,
  input  logic                      s1_arvalid,
  output logic                      s1_arready,
  output logic [DATA_WIDTH-1:0]     s1_rdata,
  output logic [1:0]                s1_rresp,
  output logic                      s1_rvalid,
  input  logic                      s1_rready,
  // slave port towards the compute unit
  output logic [ADDR_WIDTH-1:0]     m_axi_awaddr,
  output logic [2:0]                m_axi_awprot,
  output logic                      m_axi_awvalid,
  input  logic                      m_axi_awready,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb,
  output logic                      m_axi_wvalid,
  input  logic                      m_axi_wready,
  input  logic [1:0]                m_axi_bresp,
  input  logic                      m_axi_bvalid,
  output logic                      m_axi_bready,
  output logic [ADDR_WIDTH-1:0]     m_axi_araddr,
  output logic [2:0]                m_axi_arprot,
  output logic                      m_axi_arvalid,
  input  logic                      m_axi_arready,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata,
  input  logic [1:0]                m_axi_rresp,
  input  logic                      m_axi_rvalid,
  output logic                      m_axi_rready,
  output logic                      grant_id,
  output logic                      busy
);

  typedef enum logic [2:0] {StIdle, StWr, StWb, StRa, StRd} state_e;

  state_e r_state, w_state_nxt;
  logic   r_last, w_last_nxt;
  logic   r_grant, w_grant_nxt;
  logic   r_aw_done, w_aw_done_nxt;
  logic   r_w_done, w_w_done_nxt;

  logic w_req0, w_req1, w_arb_id, w_arb_aw;
  logic w_g_awvalid, w_g_wvalid, w_g_bready, w_g_arvalid, w_g_rready;
  logic w_gx_awready, w_gx_wready, w_gx_bvalid, w_gx_arready, w_gx_rvalid;
  logic w_aw_hs, w_w_hs, w_b_hs, w_ar_hs, w_r_hs;

  // Arbitration only looks at master valids, never at slave ready.
  assign w_req0   = s0_awvalid | s0_arvalid;
  assign w_req1   = s1_awvalid | s1_arvalid;
  assign w_arb_id = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_arb_aw = w_arb_id ? s1_awvalid : s0_awvalid;

  assign w_g_awvalid = r_grant ? s1_awvalid : s0_awvalid;
  assign w_g_wvalid  = r_grant ? s1_wvalid  : s0_wvalid;
  assign w_g_bready  = r_grant ? s1_bready  : s0_bready;
  assign w_g_arvalid = r_grant ? s1_arvalid : s0_arvalid;
  assign w_g_rready  = r_grant ? s1_rready  : s0_rready;

  assign m_axi_awaddr = r_grant ? s1_awaddr : s0_awaddr;
  assign m_axi_awprot = r_grant ? s1_awprot : s0_awprot;
  assign m_axi_wdata  = r_grant ? s1_wdata  : s0_wdata;
  assign m_axi_wstrb  = r_grant ? s1_wstrb  : s0_wstrb;
  assign m_axi_araddr = r_grant ? s1_araddr : s0_araddr;
  assign m_axi_arprot = r_grant ? s1_arprot : s0_arprot;

  assign w_aw_hs = m_axi_awvalid & m_axi_awready;
  assign w_w_hs  = m_axi_wvalid  & m_axi_wready;
  assign w_b_hs  = m_axi_bvalid  & m_axi_bready;
  assign w_ar_hs = m_axi_arvalid & m_axi_arready;
  assign w_r_hs  = m_axi_rvalid  & m_axi_rready;

  always_ff @(posedge chipset_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= StIdle;
      r_last    <= 1'b1;
      r_grant   <= 1'b0;
      r_aw_done <= 1'b0;
      r_w_done  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_last    <= w_last_nxt;
      r_grant   <= w_grant_nxt;
      r_aw_done <= w_aw_done_nxt;
      r_w_done  <= w_w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_last_nxt    = r_last;
    w_grant_nxt   = r_grant;
    w_aw_done_nxt = r_aw_done;
    w_w_done_nxt  = r_w_done;
    unique case (r_state)
      StIdle: begin
        if (w_req0 | w_req1) begin
          w_grant_nxt = w_arb_id;
          w_last_nxt  = w_arb_id;
          w_state_nxt = w_arb_aw ? StWr : StRa;
        end
      end
      StWr: begin
        if ((r_aw_done | w_aw_hs) & (r_w_done | w_w_hs)) begin
          w_state_nxt   = StWb;
          w_aw_done_nxt = 1'b0;
          w_w_done_nxt  = 1'b0;
        end else begin
          w_aw_done_nxt = r_aw_done | w_aw_hs;
          w_w_done_nxt  = r_w_done | w_w_hs;
        end
      end
      StWb:    if (w_b_hs)  w_state_nxt = StIdle;
      StRa:    if (w_ar_hs) w_state_nxt = StRd;
      StRd:    if (w_r_hs)  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
  end

  // Slave-facing valids/readies plus the "granted master" view of slave outputs.
  always_comb begin
    m_axi_awvalid = 1'b0;
    m_axi_wvalid  = 1'b0;
    m_axi_bready  = 1'b0;
    m_axi_arvalid = 1'b0;
    m_axi_rready  = 1'b0;
    w_gx_awready  = 1'b0;
    w_gx_wready   = 1'b0;
    w_gx_bvalid   = 1'b0;
    w_gx_arready  = 1'b0;
    w_gx_rvalid   = 1'b0;
    unique case (r_state)
      StWr: begin
        m_axi_awvalid = w_g_awvalid & ~r_aw_done;
        m_axi_wvalid  = w_g_wvalid & ~r_w_done;
        w_gx_awready  = m_axi_awready & ~r_aw_done;
        w_gx_wready   = m_axi_wready & ~r_w_done;
      end
      StWb: begin
        m_axi_bready = w_g_bready;
        w_gx_bvalid  = m_axi_bvalid;
      end
      StRa: begin
        m_axi_arvalid = w_g_arvalid;
        w_gx_arready  = m_axi_arready;
      end
      StRd: begin
        m_axi_rready = w_g_rready;
        w_gx_rvalid  = m_axi_rvalid;
      end
      default: ;
    endcase
  end

  assign s0_awready = w_gx_awready & ~r_grant;
  assign s0_wready  = w_gx_wready  & ~r_grant;
  assign s0_bvalid  = w_gx_bvalid  & ~r_grant;
  assign s0_arready = w_gx_arready & ~r_grant;
  assign s0_rvalid  = w_gx_rvalid  & ~r_grant;
  assign s1_awready = w_gx_awready & r_grant;
  assign s1_wready  = w_gx_wready  & r_grant;
  assign s1_bvalid  = w_gx_bvalid  & r_grant;
  assign s1_arready = w_gx_arready & r_grant;
  assign s1_rvalid  = w_gx_rvalid  & r_grant;

  assign s0_bresp = m_axi_bresp;
  assign s1_bresp = m_axi_bresp;
  assign s0_rdata = m_axi_rdata;
  assign s1_rdata = m_axi_rdata;
  assign s0_rresp = m_axi_rresp;
  assign s1_rresp = m_axi_rresp;

  assign grant_id = r_grant;
  assign busy     = (r_state != StIdle);

endmodule

// File: tb/tb_neko_axil_arbiter.sv
// Directed bench for neko_axil_arbiter: two master drivers, a responder slave model
// and per-master scoreboards for B and R responses.
module tb_neko_axil_arbiter;

  logic clk, rst_n;

  logic [10:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr;
  logic [2:0]  s0_awprot, s1_awprot, s0_arprot, s1_arprot;
  logic        s0_awvalid, s1_awvalid, s0_awready, s1_awready;
  logic [31:0] s0_wdata, s1_wdata;
  logic [3:0]  s0_wstrb, s1_wstrb;
  logic        s0_wvalid, s1_wvalid, s0_wready, s1_wready;
  logic [1:0]  s0_bresp, s1_bresp;
  logic        s0_bvalid, s1_bvalid, s0_bready, s1_bready;
  logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
  logic [31:0] s0_rdata, s1_rdata;
  logic [1:0]  s0_rresp, s1_rresp;
  logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready;

  logic [10:0] m_axi_awaddr, m_axi_araddr;
  logic [2:0]  m_axi_awprot, m_axi_arprot;
  logic        m_axi_awvalid, m_axi_awready, m_axi_wvalid, m_axi_wready;
  logic [31:0] m_axi_wdata, m_axi_rdata;
  logic [3:0]  m_axi_wstrb;
  logic [1:0]  m_axi_bresp, m_axi_rresp;
  logic        m_axi_bvalid, m_axi_bready, m_axi_arvalid, m_axi_arready;
  logic        m_axi_rvalid, m_axi_rready;
  logic        grant_id, busy;

  neko_axil_arbiter #(.ADDR_WIDTH(11), .DATA_WIDTH(32)) dut (
    .chipset_clk(clk), .rst_n(rst_n),
    .s0_awaddr(s0_awaddr), .s0_awprot(s0_awprot), .s0_awvalid(s0_awvalid),
    .s0_awready(s0_awready), .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb),
    .s0_wvalid(s0_wvalid), .s0_wready(s0_wready), .s0_bresp(s0_bresp),
    .s0_bvalid(s0_bvalid), .s0_bready(s0_bready), .s0_araddr(s0_araddr),
    .s0_arprot(s0_arprot), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_awaddr(s1_awaddr), .s1_awprot(s1_awprot), .s1_awvalid(s1_awvalid),
    .s1_awready(s1_awready), .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb),
    .s1_wvalid(s1_wvalid), .s1_wready(s1_wready), .s1_bresp(s1_bresp),
    .s1_bvalid(s1_bvalid), .s1_bready(s1_bready), .s1_araddr(s1_araddr),
    .s1_arprot(s1_arprot), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_axi_awaddr(m_axi_awaddr), .m_axi_awprot(m_axi_awprot), .m_axi_awvalid(m_axi_awvalid),
    .m_axi_awready(m_axi_awready), .m_axi_wdata(m_axi_wdata), .m_axi_wstrb(m_axi_wstrb),
    .m_axi_wvalid(m_axi_wvalid), .m_axi_wready(m_axi_wready), .m_axi_bresp(m_axi_bresp),
    .m_axi_bvalid(m_axi_bvalid), .m_axi_bready(m_axi_bready), .m_axi_araddr(m_axi_araddr),
    .m_axi_arprot(m_axi_arprot), .m_axi_arvalid(m_axi_arvalid),
    .m_axi_arready(m_axi_arready), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
    .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready),
    .grant_id(grant_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Slave model: always-ready address/data, response one cycle after the request completes.
  logic        sl_bvalid, sl_got_aw, sl_got_w, sl_rpend, sl_rhold;
  logic [1:0]  sl_bresp, sl_rresp;
  logic [31:0] sl_rdata, cap_wdata;
  logic [10:0] cap_awaddr, sl_aw_now;
  logic        sl_aw_hs, sl_w_hs;

  assign sl_aw_hs     = m_axi_awvalid & m_axi_awready;
  assign sl_w_hs      = m_axi_wvalid & m_axi_wready;
  assign sl_aw_now    = sl_aw_hs ? m_axi_awaddr : cap_awaddr;
  assign m_axi_bvalid = sl_bvalid;
  assign m_axi_bresp  = sl_bresp;
  assign m_axi_rvalid = sl_rpend & ~sl_rhold;
  assign m_axi_rdata  = sl_rdata;
  assign m_axi_rresp  = sl_rresp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sl_bvalid <= 1'b0;
      sl_got_aw <= 1'b0;
      sl_got_w  <= 1'b0;
      sl_rpend  <= 1'b0;
    end else begin
      if (sl_aw_hs) cap_awaddr <= m_axi_awaddr;
      if (sl_w_hs)  cap_wdata  <= m_axi_wdata;
      if (sl_bvalid) begin
        if (m_axi_bready) sl_bvalid <= 1'b0;
      end else if ((sl_got_aw | sl_aw_hs) & (sl_got_w | sl_w_hs)) begin
        sl_bvalid <= 1'b1;
        sl_bresp  <= {sl_aw_now[4], 1'b0};
        sl_got_aw <= 1'b0;
        sl_got_w  <= 1'b0;
      end else begin
        sl_got_aw <= sl_got_aw | sl_aw_hs;
        sl_got_w  <= sl_got_w | sl_w_hs;
      end
      if (m_axi_arvalid & m_axi_arready) begin
        sl_rpend <= 1'b1;
        sl_rdata <= 32'hA500_0000 ^ {21'b0, m_axi_araddr};
        sl_rresp <= {m_axi_araddr[5], 1'b0};
      end else if (m_axi_rvalid & m_axi_rready) begin
        sl_rpend <= 1'b0;
      end
    end
  end

  // Scoreboards: write entries {addr, data, bresp}, read entries {rdata, rresp}.
  logic [44:0] wq0[$], wq1[$];
  logic [33:0] rq0[$], rq1[$];

  task automatic mon_b(input int m);
    logic [44:0] e;
    int sz;
    sz = (m == 0) ? wq0.size() : wq1.size();
    chk("b_expected", 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      e = (m == 0) ? wq0.pop_front() : wq1.pop_front();
      chk("b_txn", {cap_awaddr, cap_wdata, (m == 0) ? s0_bresp : s1_bresp}, 64'(e));
    end
  endtask

  task automatic mon_r(input int m);
    logic [33:0] e;
    int sz;
    sz = (m == 0) ? rq0.size() : rq1.size();
    chk("r_expected", 64'(sz != 0), 64'd1);
    if (sz != 0) begin
      e = (m == 0) ? rq0.pop_front() : rq1.pop_front();
      chk("r_txn", (m == 0) ? {s0_rdata, s0_rresp} : {s1_rdata, s1_rresp}, 64'(e));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (s0_bvalid & s0_bready) mon_b(0);
      if (s1_bvalid & s1_bready) mon_b(1);
      if (s0_rvalid & s0_rready) mon_r(0);
      if (s1_rvalid & s1_rready) mon_r(1);
    end
  end

  logic hs_aw0, hs_w0, hs_ar0, hs_b0, hs_aw1, hs_w1, hs_ar1, hs_b1;

  // One clock: sample handshakes mid-cycle, then drop valids that completed.
  task automatic cyc();
    @(negedge clk);
    hs_aw0 = s0_awvalid & s0_awready;
    hs_w0  = s0_wvalid & s0_wready;
    hs_ar0 = s0_arvalid & s0_arready;
    hs_b0  = s0_bvalid & s0_bready;
    hs_aw1 = s1_awvalid & s1_awready;
    hs_w1  = s1_wvalid & s1_wready;
    hs_ar1 = s1_arvalid & s1_arready;
    hs_b1  = s1_bvalid & s1_bready;
    @(posedge clk);
    #1;
    if (hs_aw0) s0_awvalid = 1'b0;
    if (hs_w0)  s0_wvalid  = 1'b0;
    if (hs_ar0) s0_arvalid = 1'b0;
    if (hs_aw1) s1_awvalid = 1'b0;
    if (hs_w1)  s1_wvalid  = 1'b0;
    if (hs_ar1) s1_arvalid = 1'b0;
  endtask

  task automatic arm_wr(input int m, input logic [10:0] a, input logic [31:0] d);
    if (m == 0) begin
      s0_awaddr = a; s0_awvalid = 1'b1; s0_wdata = d; s0_wstrb = 4'hF; s0_wvalid = 1'b1;
      wq0.push_back({a, d, a[4], 1'b0});
    end else begin
      s1_awaddr = a; s1_awvalid = 1'b1; s1_wdata = d; s1_wstrb = 4'hF; s1_wvalid = 1'b1;
      wq1.push_back({a, d, a[4], 1'b0});
    end
  endtask

  task automatic arm_rd(input int m, input logic [10:0] a);
    if (m == 0) begin
      s0_araddr = a; s0_arvalid = 1'b1;
      rq0.push_back({32'hA500_0000 ^ {21'b0, a}, a[5], 1'b0});
    end else begin
      s1_araddr = a; s1_arvalid = 1'b1;
      rq1.push_back({32'hA500_0000 ^ {21'b0, a}, a[5], 1'b0});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
    s1_awvalid = 0; s1_wvalid = 0; s1_arvalid = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int done_cnt, armed, seq[$];

  initial begin
    s0_awaddr = 0; s0_awprot = 0; s0_wdata = 0; s0_wstrb = 0; s0_araddr = 0; s0_arprot = 0;
    s1_awaddr = 0; s1_awprot = 0; s1_wdata = 0; s1_wstrb = 0; s1_araddr = 0; s1_arprot = 0;
    s0_bready = 1; s0_rready = 1; s1_bready = 1; s1_rready = 1;
    m_axi_awready = 1; m_axi_wready = 1; m_axi_arready = 1; sl_rhold = 0;
    rst_n = 1'b0;
    s0_awvalid = 0; s0_wvalid = 0; s0_arvalid = 0;
    s1_awvalid = 0; s1_wvalid = 0; s1_arvalid = 0;
    #12;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    do_reset();

    // Single write from s0: IDLE, WR (both handshakes), WB, IDLE.
    arm_wr(0, 11'h004, 32'hDEAD_BEEF);
    #1 chk("wr_idle_no_fwd", {63'd0, m_axi_awvalid}, 64'd0);
    cyc();
    chk("wr_c1_valids", {busy, m_axi_awvalid, m_axi_wvalid, s0_awready, s0_wready}, 64'h1F);
    chk("wr_c1_addr", 64'(m_axi_awaddr), 64'h004);
    chk("wr_c1_grant", 64'(grant_id), 64'd0);
    cyc();
    chk("wr_c2_bvalid", {s0_bvalid, s1_bvalid}, 64'b10);
    cyc();
    chk("wr_done_idle", 64'(busy), 64'd0);

    // Simultaneous reads from reset: s0 first, then s1 after one idle cycle.
    do_reset();
    arm_rd(0, 11'h010);
    arm_rd(1, 11'h020);
    cyc();
    chk("rd_a_ra", {grant_id, m_axi_arvalid, s0_arready, s1_arready}, 64'b0110);
    chk("rd_a_addr", 64'(m_axi_araddr), 64'h010);
    cyc();
    chk("rd_a_rd", {s0_rvalid, s1_rvalid, m_axi_rready}, 64'b101);
    cyc();
    chk("rd_gap_idle", {busy, m_axi_arvalid}, 64'd0);
    cyc();
    chk("rd_b_ra", {grant_id, m_axi_arvalid, s0_arready, s1_arready}, 64'b1101);
    chk("rd_b_addr", 64'(m_axi_araddr), 64'h020);
    cyc();
    chk("rd_b_rd", {s0_rvalid, s1_rvalid}, 64'b01);
    cyc();

    // s0 write and read together: write first, read after one idle cycle.
    arm_wr(0, 11'h030, 32'h1234_5678);
    arm_rd(0, 11'h040);
    cyc();
    chk("wa_wr_first", {grant_id, m_axi_awvalid, m_axi_arvalid}, 64'b010);
    cyc();
    chk("wa_wb", 64'(s0_bvalid), 64'd1);
    cyc();
    chk("wa_idle", {busy, m_axi_arvalid}, 64'd0);
    cyc();
    chk("wa_ra", {m_axi_arvalid, m_axi_araddr}, {52'd1, 11'h040});
    cyc();
    cyc();

    // W before AW on s1, with AW then stalled by the slave.
    s1_wdata = 32'hCAFE_F00D; s1_wstrb = 4'h3; s1_wvalid = 1'b1;
    repeat (3) cyc();
    chk("wfirst_idle", {busy, m_axi_wvalid}, 64'd0);
    m_axi_awready = 1'b0;
    s1_awaddr = 11'h050; s1_awprot = 3'b010; s1_awvalid = 1'b1;
    wq1.push_back({11'h050, 32'hCAFE_F00D, 2'b10});
    cyc();
    chk("wfirst_wr", {m_axi_awvalid, m_axi_wvalid, s1_wready, s1_awready}, 64'b1110);
    chk("wfirst_mux", {m_axi_awprot, m_axi_wstrb}, {3'b010, 4'h3});
    cyc();
    chk("wfirst_wdone", {busy, s1_wready, s1_bvalid}, 64'b100);
    s1_wvalid = 1'b1;
    #1 chk("wfirst_no_2nd_w", 64'(m_axi_wvalid), 64'd0);
    s1_wvalid = 1'b0;
    cyc();
    chk("wfirst_still_wr", {busy, s1_bvalid, m_axi_awvalid}, 64'b101);
    m_axi_awready = 1'b1;
    #1 chk("wfirst_awready", 64'(s1_awready), 64'd1);
    cyc();
    chk("wfirst_wb", {s1_bvalid, s1_bresp}, {1'b1, 2'b10});
    cyc();

    // Fairness: both masters keep requesting writes.
    done_cnt = 0;
    armed = 0;
    arm_wr(0, 11'h100, 32'hF00D_0000); armed++;
    arm_wr(1, 11'h108, 32'hF00D_0001); armed++;
    for (int c = 0; c < 80 && done_cnt < 6; c++) begin
      cyc();
      if (hs_b0) begin
        seq.push_back(0); done_cnt++;
        if (armed < 6) begin
          arm_wr(0, 11'h100 | 11'(armed << 3), 32'hF00D_0000 | armed); armed++;
        end
      end
      if (hs_b1) begin
        seq.push_back(1); done_cnt++;
        if (armed < 6) begin
          arm_wr(1, 11'h100 | 11'(armed << 3), 32'hF00D_0000 | armed); armed++;
        end
      end
    end
    chk("fair_count", 64'(done_cnt), 64'd6);
    for (int k = 0; k < seq.size(); k++) chk("fair_seq", 64'(seq[k]), 64'(k % 2));

    // Reset in RD while the slave holds rvalid low.
    sl_rhold = 1'b1;
    s1_araddr = 11'h060; s1_arvalid = 1'b1;
    cyc();
    cyc();
    chk("rstrd_in_rd", {busy, grant_id, m_axi_rready, s1_rvalid}, 64'b1110);
    rst_n = 1'b0;
    #1;
    chk("rstrd_outs", {busy, grant_id, m_axi_rready, m_axi_arvalid, m_axi_awvalid,
                       m_axi_wvalid, m_axi_bready, s1_rvalid, s1_arready}, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    sl_rhold = 1'b0;
    arm_rd(0, 11'h070);
    arm_rd(1, 11'h0A0);
    cyc();
    chk("rstrd_first_s0", {grant_id, m_axi_araddr}, {1'b0, 11'h070});
    repeat (5) cyc();
    chk("queues_drained", 64'(wq0.size() + wq1.size() + rq0.size() + rq1.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
